// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: sums a WIDTH-bit operand pair CHUNK bits per clock,
// holding the inter-chunk carry in a register, with valid/ready on both sides.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   idx_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              cout_reg, overflow_reg;

  logic [CHUNK-1:0]  a_chunk [NCHUNK];
  logic [CHUNK-1:0]  b_chunk [NCHUNK];
  logic [CHUNK-1:0]  sum_chunk_reg [NCHUNK];
  logic [CHUNK-1:0]  a_sel, b_sel, s_cur;
  logic [CHUNK:0]    chunk_sum;
  logic              last_chunk, msb_carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign sum[gi*CHUNK +: CHUNK] = sum_chunk_reg[gi];

      always_ff @(posedge clk) begin
        if (rst)
          sum_chunk_reg[gi] <= '0;
        else if (state_reg == ADD && idx_reg == IDXW'(gi))
          sum_chunk_reg[gi] <= s_cur;
      end
    end
  endgenerate

  assign a_sel      = a_chunk[idx_reg];
  assign b_sel      = b_chunk[idx_reg];
  assign chunk_sum  = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_reg};
  assign s_cur      = chunk_sum[CHUNK-1:0];
  assign last_chunk = (idx_reg == IDXW'(NCHUNK - 1));
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
  assign msb_carry_in = a_sel[CHUNK-1] ^ b_sel[CHUNK-1] ^ s_cur[CHUNK-1];

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ADD;
      ADD:     if (last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      idx_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      // Subtraction is a + ~b + 1; cin only matters for addition.
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
      idx_reg   <= '0;
    end else if (state_reg == ADD) begin
      carry_reg <= chunk_sum[CHUNK];
      idx_reg   <= idx_reg + 1'b1;
      if (last_chunk) begin
        cout_reg     <= chunk_sum[CHUNK];
        overflow_reg <= chunk_sum[CHUNK] ^ msb_carry_in;
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Randomised and directed bench for chunked_serial_adder against an arithmetic reference model.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [15:0] a, b, sum;
  int          checks = 0;
  int          errors = 0;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // Reference: plain 17-bit arithmetic; overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] full;
    logic        ov;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    ov   = (x[15] == yy[15]) && (full[15] != x[15]);
    return {ov, full};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation and waits (bounded) for out_valid; does not consume the result.
  task automatic start_and_wait(input logic [15:0] x, input logic [15:0] y, input logic c,
                                input logic s, output int lat, output bit timeout);
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    timeout = !out_valid;
  endtask

  task automatic check_result(input string name, input logic [15:0] es, input logic ec,
                              input logic eo);
    checks++;
    if (sum !== es || cout !== ec || overflow !== eo) begin
      errors++;
      $display("FAIL %s: got sum=%h cout=%b ov=%b, required sum=%h cout=%b ov=%b",
               name, sum, cout, overflow, es, ec, eo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0
        || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b sum=%h cout=%b ov=%b, required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, overflow);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got in_ready=%b, required 1", in_ready);
    end
    $display("reset: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, sum);
  endtask

  task automatic test_latency();
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL latency_k%0d: got rdy=%b vld=%b, required rdy=0 vld=%b",
                 k, in_ready, out_valid, (k == 4));
      end
      if (k < 4) tick();
    end
    check_result("latency_result", 16'h5555, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_release: got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    $display("latency: 1234+4321 sum=%h", sum);
  endtask

  typedef struct {
    logic [15:0] x, y;
    logic        c, s;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    int   lat;
    bit   to;
    v[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    v[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[6] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    v[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      start_and_wait(v[i].x, v[i].y, v[i].c, v[i].s, lat, to);
      checks++;
      if (to || lat != 4) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d cycles (timeout=%0b), required 4", i, lat, to);
      end
      check_result($sformatf("directed%0d", i), v[i].es, v[i].ec, v[i].eo);
      $display("directed%0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ov=%b",
               i, v[i].x, v[i].y, v[i].c, v[i].s, sum, cout, overflow);
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    bit          to;
    logic [17:0] exp;
    out_ready = 1'b0;
    exp = model(16'hA5C3, 16'h1E77, 1'b1, 1'b0);
    start_and_wait(16'hA5C3, 16'h1E77, 1'b1, 1'b0, lat, to);
    if (to) begin
      checks++; errors++;
      $display("FAIL bp_timeout: got out_valid=0, required 1");
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      tick();
      check_result($sformatf("bp_hold%0d", k), exp[15:0], exp[16], exp[17]);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall%0d: got rdy=%b vld=%b, required 0 1", k, in_ready, out_valid);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
    exp = model(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    start_and_wait(16'h0F0F, 16'h00F1, 1'b0, 1'b1, lat, to);
    check_result("bp_next", exp[15:0], exp[16], exp[17]);
    $display("backpressure: held then next sum=%h", sum);
    tick();
  endtask

  task automatic test_reset_mid();
    int          lat;
    bit          to;
    bit          seen;
    logic [17:0] exp;
    a = 16'h4444; b = 16'h3333; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got rdy=%b vld=%b sum=%h cout=%b, required 1 0 0000 0",
               in_ready, out_valid, sum, cout);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_abort: got out_valid=1 after abort, required 0");
    end
    exp = model(16'h00FF, 16'h0001, 1'b0, 1'b0);
    start_and_wait(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, to);
    check_result("rst_after", 16'h0100, 1'b0, 1'b0);
    check_result("rst_after_model", exp[15:0], exp[16], exp[17]);
    $display("reset_mid: aborted, next 00FF+0001 sum=%h", sum);
    tick();
  endtask

  task automatic test_random();
    int          lat;
    bit          to;
    logic [15:0] x, y;
    logic        c, s;
    logic [17:0] exp;
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
      if (i % 8 == 0) x = 16'h8000 | x;
      if (i % 8 == 1) y = ~x;
      exp = model(x, y, c, s);
      start_and_wait(x, y, c, s, lat, to);
      checks++;
      if (to || lat != 4) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d cycles (timeout=%0b), required 4", i, lat, to);
      end
      check_result($sformatf("rand%0d", i), exp[15:0], exp[16], exp[17]);
      $display("rand%0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ov=%b",
               i, x, y, c, s, sum, cout, overflow);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
